frame_scheduler: RTL

Frame-rate scheduler for the game logic in the ArcadeTennis design. It watches the pixel counters produced by the VGA timing generator and detects the start of vertical blanking. At that point it runs the game-update tasks (paddle move, ball move, collision, score) one after another, in a fixed order. Each task gets a start/done handshake and a cycle budget, so object state only changes while nothing is being drawn.

---
 rtl/frame_sched_pkg.sv | 22 ++
 rtl/frame_tick_gen.sv | 59 +++++
 rtl/frame_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/frame_sched_pkg.sv
// rtl/frame_sched_pkg.sv - shared types, defaults and sizing helper for the frame scheduler
package frame_sched_pkg;

    // Sequencer states; k (the task index) is held separately.
    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        NEXT,
        DONE
    } sched_state_e;

    localparam int DEF_N_TASKS   = 4;
    localparam int DEF_TIMEOUT   = 4095;
    localparam int DEF_V_DISPLAY = 480;

    // Bits needed for a timer that counts 0..timeout inclusive.
    function automatic int timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - frame-event detect, frame divider and frame counter
//
// Ports:
//   clk_i, rst_ni    clock and asynchronous active-low reset
//   p_tick_i         pixel-rate enable from the timing generator
//   x_i, y_i         pixel / line counters
//   launch_tick_o    high in the cycle whose edge is a launch candidate
//   frame_cnt_o      frame-event count, wraps modulo 2^16
module frame_tick_gen
    import frame_sched_pkg::*;
#(
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int FRAME_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        p_tick_i,
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    output logic        launch_tick_o,
    output logic [15:0] frame_cnt_o
);

    localparam logic [9:0] V_LINE   = 10'(V_DISPLAY);
    localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

    logic        frame_evt;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Gating by p_tick makes the x==0 pixel last exactly one sampling edge.
    assign frame_evt = p_tick_i && (x_i == 10'd0) && (y_i == V_LINE);

    // Combinational so the scheduler can leave IDLE on the event edge itself;
    // it only feeds registered state, never a top-level output.
    assign launch_tick_o = frame_evt && (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d   = div_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_evt) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            div_cnt_d   = (div_cnt_q == DIV_LAST) ? 8'd0 : div_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - vertical-blanking sequencer for the game-update tasks
//
// Ports:
//   clk, reset       clock and asynchronous active-low reset
//   p_tick, x, y     timing-generator enable and counters
//   pause            blocks a launch when high at the frame event
//   task_en          per-task enable mask, taken when a task's START is entered
//   task_done        per-task completion, honoured only for the waiting task
//   task_start       one-hot single-cycle start pulse
//   busy             sequencer not idle
//   seq_done         single-cycle end-of-sequence pulse
//   overrun          single-cycle pulse when a launch candidate meets a busy sequencer
//   timeout_err      sticky per-task timeout flags
//   frame_cnt        frame-event counter
module frame_scheduler
    import frame_sched_pkg::*;
#(
    parameter int N_TASKS   = DEF_N_TASKS,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int FRAME_DIV = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p_tick,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               pause,
    input  logic [N_TASKS-1:0] task_en,
    input  logic [N_TASKS-1:0] task_done,
    output logic [N_TASKS-1:0] task_start,
    output logic               busy,
    output logic               seq_done,
    output logic               overrun,
    output logic [N_TASKS-1:0] timeout_err,
    output logic [15:0]        frame_cnt
);

    localparam int KW = (N_TASKS > 1) ? $clog2(N_TASKS) : 1;
    localparam int TW = timer_width(TIMEOUT);
    localparam logic [KW-1:0] K_LAST = KW'(N_TASKS - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);

    sched_state_e       state_q, state_d;
    logic [KW-1:0]      k_q, k_d, k_inc;
    logic [TW-1:0]      timer_q, timer_d;
    logic [N_TASKS-1:0] err_q, err_d;
    logic [N_TASKS-1:0] start_q, start_d;
    logic               overrun_q, overrun_d;
    logic               launch_tick;

    frame_tick_gen #(
        .V_DISPLAY (V_DISPLAY),
        .FRAME_DIV (FRAME_DIV)
    ) u_tick (
        .clk_i         (clk),
        .rst_ni        (reset),
        .p_tick_i      (p_tick),
        .x_i           (x),
        .y_i           (y),
        .launch_tick_o (launch_tick),
        .frame_cnt_o   (frame_cnt)
    );

    assign k_inc = k_q + 1'b1;

    // The start pulse is registered on entry to START so that it is visible
    // during the START cycle without a combinational path from task_en.
    // A non-zero start_q in START therefore means "this task is enabled".
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        timer_d   = timer_q;
        err_d     = err_q;
        start_d   = '0;
        overrun_d = launch_tick && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (launch_tick && !pause) begin
                    k_d        = '0;
                    state_d    = START;
                    start_d[0] = task_en[0];
                end
            end
            START: begin
                if (|start_q) begin
                    timer_d = '0;
                    state_d = WAIT;
                end else begin
                    state_d = NEXT;
                end
            end
            WAIT: begin
                // Done is tested first so it wins over a coincident timeout.
                if (task_done[k_q]) begin
                    state_d = NEXT;
                end else if (timer_q == T_MAX) begin
                    err_d[k_q] = 1'b1;
                    state_d    = NEXT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            NEXT: begin
                if (k_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    k_d            = k_inc;
                    state_d        = START;
                    start_d[k_inc] = task_en[k_inc];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            timer_q   <= '0;
            err_q     <= '0;
            start_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            start_q   <= start_d;
            overrun_q <= overrun_d;
        end
    end

    assign task_start  = start_q;
    assign busy        = (state_q != IDLE);
    assign seq_done    = (state_q == DONE);
    assign overrun     = overrun_q;
    assign timeout_err = err_q;

endmodule
